// File: rtl/md_pkg.sv
// Shared op codes, FSM encoding and op classification for the multiply/divide unit.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } mdOpT;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdStateT;

  function automatic logic isMul(input logic [3:0] op);
    return (op == OP_MULT)  || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB)  || (op == OP_MSUBU);
  endfunction

  function automatic logic isDiv(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath: produces the next {hi,lo} for every multi-cycle op,
// including the accumulate forms, divide-by-zero and signed-overflow results.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] sProd;
  logic [2*WIDTH-1:0] uProd;
  logic               isSigned;
  logic               negA;
  logic               negB;
  logic               divZero;
  logic               sOvf;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   uQuot;
  logic [WIDTH-1:0]   uRem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign acc   = {hi, lo};
  assign sProd = $signed({{WIDTH{rs_data[WIDTH-1]}}, rs_data}) *
                 $signed({{WIDTH{rt_data[WIDTH-1]}}, rt_data});
  assign uProd = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  // One magnitude divider serves both signed and unsigned forms; signs are restored afterwards.
  assign isSigned = (op == OP_DIV);
  assign negA     = isSigned & rs_data[WIDTH-1];
  assign negB     = isSigned & rt_data[WIDTH-1];
  assign divZero  = (rt_data == '0);
  assign sOvf     = isSigned && (rs_data == MOST_NEG) && (rt_data == '1);
  assign dividend = negA ? -rs_data : rs_data;
  assign divisor  = divZero ? WIDTH'(1) : (negB ? -rt_data : rt_data);
  assign uQuot    = dividend / divisor;
  assign uRem     = dividend % divisor;
  assign quot     = (negA ^ negB) ? -uQuot : uQuot;
  assign rem      = negA ? -uRem : uRem;

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = acc;
    case (mdOpT'(op))
      OP_MULT:  result = sProd;
      OP_MULTU: result = uProd;
      OP_MADD:  result = acc + sProd;
      OP_MADDU: result = acc + uProd;
      OP_MSUB:  result = acc - sProd;
      OP_MSUBU: result = acc - uProd;
      OP_DIV, OP_DIVU: begin
        if (divZero)   result = {rs_data, {WIDTH{1'b1}}};
        else if (sOvf) result = {{WIDTH{1'b0}}, MOST_NEG};
        else           result = {rem, quot};
      end
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/md_unit_param.sv
// Multiply/divide unit with HI/LO: results are computed at start, held in shadow
// registers for the op latency, then committed; flush discards the shadow copy.
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  mdStateT            state, nextState;
  logic [CNT_W-1:0]   cnt, nextCnt;
  logic [WIDTH-1:0]   shadowHi, shadowLo, nextShadowHi, nextShadowLo;
  logic [WIDTH-1:0]   nextHi, nextLo;
  logic [2*WIDTH-1:0] arithResult;

  md_arith #(.WIDTH(WIDTH)) uArith (
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi),
    .lo      (lo),
    .result  (arithResult)
  );

  always_comb begin
    nextState    = state;
    nextCnt      = cnt;
    nextShadowHi = shadowHi;
    nextShadowLo = shadowLo;
    nextHi       = hi;
    nextLo       = lo;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (isMul(op) || isDiv(op)) begin
            {nextShadowHi, nextShadowLo} = arithResult;
            nextCnt   = isDiv(op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            nextState = BUSY;
          end else if (op == OP_MTHI) begin
            nextHi = rs_data;
          end else if (op == OP_MTLO) begin
            nextLo = rs_data;
          end
        end
      end
      BUSY: begin
        // hi/lo are untouched until commit, so a flush simply abandons the shadow copy.
        if (flush) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else if (cnt == '0) begin
          nextHi    = shadowHi;
          nextLo    = shadowLo;
          nextState = IDLE;
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shadowHi <= '0;
      shadowLo <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= nextState;
      cnt      <= nextCnt;
      shadowHi <= nextShadowHi;
      shadowLo <= nextShadowLo;
      hi       <= nextHi;
      lo       <= nextLo;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_md_unit_param.sv
// Directed self-checking bench for md_unit_param (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
module tb_md_unit_param;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [3:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int nVec = 0;
  int nMis = 0;
  int n;

  always #5 clk = ~clk;

  md_unit_param #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fl);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    flush   = fl;
    tick();
    start = 1'b0;
    op    = OP_NONE;
    flush = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 64) begin
      cycles++;
      tick();
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int lat,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    int cycles;
    pulse(o, a, b, 1'b0);
    waitIdle(cycles);
    check({tag, "_busy_cycles"}, 64'(cycles), 64'(lat));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = OP_NONE;
    rs_data = '0; rt_data = '0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    reset = 1'b1;
    tick();

    runOp("mult_neg",  OP_MULT, 32'hFFFF_FFFD, 32'd5, ML, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2, DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu",      OP_DIVU, 32'd7,         32'd2, DL, 32'd1,         32'd3);

    pulse(OP_MTLO, 32'h10, 32'h0, 1'b0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_lo",   64'(lo),   64'h10);
    pulse(OP_MTHI, 32'h0, 32'h0, 1'b0);
    check("mthi_hi",   64'(hi),   64'h0);
    runOp("madd",      OP_MADD,  32'd3,    32'd4, ML, 32'h0, 32'h1C);
    runOp("msubu",     OP_MSUBU, 32'h1C,   32'd1, ML, 32'h0, 32'h0);

    runOp("div_zero",  OP_DIVU, 32'h1234,      32'd0,         DL, 32'h1234, 32'hFFFF_FFFF);
    runOp("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DL, 32'h0,    32'h8000_0000);
    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML, 32'hFFFF_FFFE, 32'h0000_0001);
    // acc - (2 * -1) = acc + 2
    runOp("msub",      OP_MSUB,  32'd2,         32'hFFFF_FFFF, ML, 32'hFFFF_FFFE, 32'h0000_0003);
    // acc + 0x1_FFFFFFFE wraps past 2^64
    runOp("maddu_wrap", OP_MADDU, 32'hFFFF_FFFF, 32'd2,        ML, 32'h0,        32'h1);

    pulse(OP_MULT, 32'd3, 32'd3, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi",   64'(hi),   64'h0);
    check("flush_lo",   64'(lo),   64'h1);
    repeat (8) tick();
    check("flush_late_lo",   64'(lo),   64'h1);
    check("flush_late_busy", 64'(busy), 64'd0);

    pulse(OP_MULT, 32'd3, 32'd3, 1'b1);
    check("startflush_busy", 64'(busy), 64'd0);
    pulse(OP_MTLO, 32'hBEEF, 32'h0, 1'b1);
    check("startflush_mtlo", 64'(lo), 64'h1);
    pulse(OP_MTHI, 32'hCAFE, 32'h0, 1'b1);
    check("startflush_mthi", 64'(hi), 64'h0);

    pulse(OP_NONE, 32'd5, 32'd5, 1'b0);
    check("none_busy", 64'(busy), 64'd0);
    pulse(4'hF, 32'd5, 32'd5, 1'b0);
    check("undef_busy", 64'(busy), 64'd0);
    check("undef_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_0001);

    pulse(OP_DIVU, 32'd100, 32'd7, 1'b0);
    n = 0;
    while (busy && n < 64) begin
      if (n == 2) begin
        start = 1'b1; op = OP_MTLO; rs_data = 32'hDEAD;
      end else if (n == 4) begin
        start = 1'b1; op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
      end
      n++;
      tick();
      start = 1'b0;
      op    = OP_NONE;
    end
    check("busystart_cycles", 64'(n),  64'(DL));
    check("busystart_hi",     64'(hi), 64'd2);
    check("busystart_lo",     64'(lo), 64'd14);

    pulse(OP_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hilo", {32'(hi), 32'(lo)}, 64'h0);
    reset = 1'b1;
    repeat (12) tick();
    check("postreset_hilo", {32'(hi), 32'(lo)}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the EX stage of the 5-stage MIPS core.
- Successor to the fixed 32-bit mult/div block. Adds:
  - configurable width and per-operation latency;
  - multiply-accumulate operations (madd/maddu/msub/msubu);
  - a defined divide-by-zero result;
  - a flush input that cancels an in-flight operation.
- The hazard unit stalls D on any mult/div or mf/mt instruction while `start` or `busy` is high.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MUL_LAT, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; must be ≥1.
- DIV_LAT, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle pulse; launches `op` with the current operands.
- op, input, 4: operation code (md_pkg encoding).
- rs_data, input, WIDTH: forwarded rs operand.
- rt_data, input, WIDTH: forwarded rt operand.
- flush, input, 1: cancels the in-flight operation and any same-cycle start.
- busy, output, 1: high while an operation is in flight.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (`reset` == 0 at an edge):
  - state=IDLE, busy=0, hi=0, lo=0, counter=0, shadow registers=0.
  - Reset overrides every other input, including mid-operation.
- States:
  - IDLE: `busy`=0.
  - BUSY: `busy`=1.
- IDLE, start=1, flush=0, op in {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU}:
  - Compute the 2·WIDTH-bit result from rs_data/rt_data and the current {hi,lo}.
  - Latch the result into shadow_hi/shadow_lo.
  - Load counter with LAT−1, where LAT = MUL_LAT or DIV_LAT.
  - Go to BUSY.
  - `busy` rises the cycle after start.
- BUSY, counter>0: decrement counter.
- BUSY, counter==0:
  - At that edge: hi←shadow_hi, lo←shadow_lo, busy←0, state←IDLE.
  - Result is visible exactly LAT+1 cycles after the start edge; `busy` is high for exactly LAT cycles.
- MTHI/MTLO with start=1 in IDLE:
  - hi (resp. lo) ← rs_data at the next edge.
  - `busy` stays 0; no state change.
- start=1 while BUSY: ignored, with no effect on state or counter. The pipeline guarantees this does not occur; the bench checks that it is harmless.
- op=NONE or an undefined code with start=1: ignored.
- flush=1:
  - In BUSY: return to IDLE at the next edge; hi/lo keep their pre-operation values; `busy`=0 next cycle.
  - In IDLE with start=1: start is dropped, including MTHI/MTLO.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → {hi,lo}.
  - MULTU: unsigned WIDTH×WIDTH → {hi,lo}.
  - MADD/MSUB: {hi,lo} ± signed product, modulo 2^(2·WIDTH).
  - MADDU/MSUBU: {hi,lo} ± unsigned product, modulo 2^(2·WIDTH).
  - DIV/DIVU: lo=quotient, hi=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (most-negative ÷ −1): lo=most-negative, hi=0.
- Divide by zero (DIV or DIVU): lo=all ones, hi=rs_data. Full latency still applies.
- Accumulate ops read {hi,lo} at the start edge. Because hi/lo are stable during BUSY, this is always the committed value.

Decomposition:
- md_pkg holds:
  - op codes, 4 bits: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10;
  - state encoding IDLE=0, BUSY=1;
  - an is_mul/is_div classification helper.
- One sub-module, md_arith:
  - purely combinational;
  - inputs: op, rs_data, rt_data, hi, lo;
  - output: next {hi,lo}, covering the divide-by-zero and signed-overflow rules.
- md_unit_param holds the FSM, counter, shadow registers and hi/lo registers.

Test Plan (WIDTH=32, MUL_LAT=5, DIV_LAT=10):
- MULT, rs=0xFFFFFFFD, rt=5, pulse start → busy high for cycles 1–5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at cycle 6.
- DIV, rs=0xFFFFFFF9 (−7), rt=2 → busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, rs=7, rt=2 → lo=3, hi=1.
- MTLO 0x10, MTHI 0, then MADD rs=3, rt=4 → lo=0x1C, hi=0. Then MSUBU rs=0x1C, rt=1 → hi=0, lo=0.
- DIVU, rs=0x1234, rt=0 → after 10 busy cycles, lo=0xFFFFFFFF, hi=0x1234.
- MULT, then flush at busy cycle 3 → busy=0 next cycle; hi/lo unchanged. A start+flush in the same cycle → no effect.
- Reset (reset=0) at busy cycle 2 of DIV → busy=0, hi=lo=0 next cycle. Start pulsed while busy → ignored; original result unaffected.
